// File: rtl/mem_burst_client.sv
// rtl/mem_burst_client.sv - burst requester feeding one client slot of the shared-memory arbiter
// Raises req on start, streams BURST_LEN consecutive beats while granted, then releases and pulses done.
module mem_burst_client #(
  parameter int CLIENT_ID = 0,
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              write_mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] wdata_seed,
  input  logic [2:0]        granted_access,
  input  logic              enabled,
  input  logic [DATA_W-1:0] data_from_mem,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_to_mem,
  output logic              read_write,
  output logic              busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, REQ, XFER, DRAIN, DONE} state_t;

  state_t            state, next_state;
  logic [4:0]        count;
  logic [4:0]        count_inc;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] seed_q;
  logic              rd_pending;
  logic              granted;
  logic              consume;
  logic              last_beat;
  logic              accept;
  logic              req_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  assign granted   = enabled & granted_access[CLIENT_ID];
  assign consume   = granted && (state == REQ || state == XFER);
  assign last_beat = (count == 5'(BURST_LEN - 1));
  assign accept    = (state == IDLE) && start;
  assign count_inc = count + 5'd1;

  // State register; req/busy/done are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      req   <= req_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = REQ;
      REQ, XFER: begin
        if (granted) begin
          if (!last_beat)      next_state = XFER;
          else if (read_write) next_state = DONE;
          else                 next_state = DRAIN;
        end
      end
      DRAIN:    next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    req_nxt  = (next_state == REQ) || (next_state == XFER);
    busy_nxt = (next_state != IDLE);
    done_nxt = (next_state == DONE);
  end

  // Beat datapath: addr/data hold while ungranted so a stalled beat is replayed, never skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      base_q      <= '0;
      seed_q      <= '0;
      addr        <= '0;
      data_to_mem <= '0;
      read_write  <= 1'b0;
      rd_pending  <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      if (accept) begin
        base_q      <= base_addr;
        seed_q      <= wdata_seed;
        addr        <= base_addr;
        data_to_mem <= wdata_seed;
        read_write  <= write_mode;
        count       <= '0;
      end else if (consume && !last_beat) begin
        count       <= count_inc;
        addr        <= base_q + ADDR_W'(count_inc);
        data_to_mem <= seed_q + DATA_W'(count_inc);
      end
      // Memory answers one cycle after the address, so capture on the following edge.
      rd_pending <= consume && !read_write;
      rd_valid   <= rd_pending;
      if (rd_pending) rd_data <= data_from_mem;
    end
  end

endmodule

// File: tb/tb_mem_burst_client.sv
// tb/tb_mem_burst_client.sv - self-checking bench for mem_burst_client
// Burst-level model predicts beats, read returns, done and req/busy; directed literals pin the model.
module tb_mem_burst_client;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        write_mode;
  logic [7:0]  base_addr;
  logic [31:0] wdata_seed;
  logic [2:0]  granted_access;
  logic        enabled;
  logic [31:0] data_from_mem;
  logic        req;
  logic [7:0]  addr;
  logic [31:0] data_to_mem;
  logic        read_write;
  logic        busy;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;

  mem_burst_client #(.CLIENT_ID(1), .BURST_LEN(4), .ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .write_mode(write_mode),
    .base_addr(base_addr), .wdata_seed(wdata_seed), .granted_access(granted_access),
    .enabled(enabled), .data_from_mem(data_from_mem), .req(req), .addr(addr),
    .data_to_mem(data_to_mem), .read_write(read_write), .busy(busy),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done)
  );

  always #5 clk = ~clk;

  // Memory returns {24'h0, addr} one cycle after the address is presented.
  always @(posedge clk) data_from_mem <= {24'h0, addr};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  typedef struct {int due; logic [31:0] d;} rd_t;

  int          cyc = 0;
  bit          m_busy = 0, m_req = 0, m_mode = 0;
  logic [7:0]  m_base;
  logic [31:0] m_seed;
  int          m_i = 0;
  int          m_done_at = -1;
  rd_t         rdq[$];
  int          done_cnt = 0, start_cyc = 0, last_lat = 0;
  int          low_run = 0, last_gap = 0;
  logic [7:0]  obs_addr[$];
  logic [31:0] obs_data[$];
  logic [31:0] obs_rd[$];
  logic [7:0]  exp_a;
  logic [31:0] exp_d;

  // Model and per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_req", req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_addr", addr, 0);
      chk("rst_data", data_to_mem, 0);
      chk("rst_rw", read_write, 0);
      chk("rst_rd_data", rd_data, 0);
      m_busy = 0; m_req = 0; m_done_at = -1; rdq.delete(); low_run = 0;
    end else begin
      chk("req", req, m_req);
      chk("busy", busy, m_busy);
      chk("done", done, cyc == m_done_at);
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, rdq[0].d);
        void'(rdq.pop_front());
      end else begin
        chk("rd_valid", rd_valid, 0);
      end
      if (m_busy) chk("read_write", read_write, m_mode);
      if (done) begin done_cnt++; last_lat = cyc - start_cyc; end
      if (rd_valid) obs_rd.push_back(rd_data);
      if (req && low_run > 0) last_gap = low_run;
      low_run = req ? 0 : low_run + 1;
      if (m_req) begin
        exp_a = m_base + m_i[7:0];
        exp_d = m_seed + 32'(m_i);
        chk("addr", addr, exp_a);
        chk("data_to_mem", data_to_mem, exp_d);
        if (enabled && granted_access[1]) begin
          obs_addr.push_back(addr);
          obs_data.push_back(data_to_mem);
          if (!m_mode) rdq.push_back('{cyc + 2, {24'h0, exp_a}});
          m_i++;
          if (m_i == 4) begin
            m_req = 0;
            m_done_at = cyc + (m_mode ? 1 : 2);
          end
        end
      end
      if (!m_busy && start) begin
        m_busy = 1; m_req = 1; m_mode = write_mode;
        m_base = base_addr; m_seed = wdata_seed; m_i = 0; start_cyc = cyc;
      end
      if (cyc == m_done_at) m_busy = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic mode, input logic [7:0] b, input logic [31:0] s);
    start = 1; write_mode = mode; base_addr = b; wdata_seed = s;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin tick(); n++; end
    chk("done_seen", done_cnt != d0, 1);
  endtask

  task automatic wait_beats(input int k);
    int n = 0;
    while (obs_addr.size() < k && n < 40) begin tick(); n++; end
    chk("beats_reached", obs_addr.size() >= k, 1);
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_data.delete(); obs_rd.delete();
  endtask

  int dc;

  initial begin
    rst_n = 0; start = 0; write_mode = 0; base_addr = 0; wdata_seed = 0;
    granted_access = 3'b010; enabled = 1;
    repeat (3) tick();
    rst_n = 1;
    tick();

    // Write burst, continuous grant
    clear_obs();
    do_start(1, 8'hA2, 32'hD2);
    wait_done(30);
    chk("wr_nbeats", obs_addr.size(), 4);
    chk("wr_a0", obs_addr[0], 8'hA2); chk("wr_a3", obs_addr[3], 8'hA5);
    chk("wr_d0", obs_data[0], 32'hD2); chk("wr_d3", obs_data[3], 32'hD5);
    chk("wr_latency", last_lat, 5);
    tick();
    chk("wr_req_after", req, 0);

    // Read burst with address wrap
    clear_obs();
    do_start(0, 8'hFE, 32'h0);
    wait_done(30);
    chk("rd_n", obs_rd.size(), 4);
    chk("rd_0", obs_rd[0], 32'hFE); chk("rd_1", obs_rd[1], 32'hFF);
    chk("rd_2", obs_rd[2], 32'h00); chk("rd_3", obs_rd[3], 32'h01);
    chk("rd_latency", last_lat, 6);
    repeat (2) tick();

    // Grant stall of 3 cycles after beat 1
    clear_obs();
    do_start(1, 8'h10, 32'h100);
    wait_beats(2);
    enabled = 0;
    repeat (3) tick();
    chk("stall_addr_hold", addr, 8'h12);
    enabled = 1;
    wait_done(40);
    chk("stall_nbeats", obs_addr.size(), 4);
    chk("stall_a2", obs_addr[2], 8'h12); chk("stall_a3", obs_addr[3], 8'h13);
    chk("stall_latency", last_lat, 8);
    repeat (2) tick();

    // Wrong-slot grant, then correct slot
    clear_obs();
    granted_access = 3'b001;
    do_start(1, 8'h40, 32'h0);
    repeat (5) tick();
    chk("ws_nbeats", obs_addr.size(), 0);
    chk("ws_req", req, 1);
    granted_access = 3'b100;
    repeat (3) tick();
    chk("ws_nbeats2", obs_addr.size(), 0);
    granted_access = 3'b010;
    wait_done(30);
    chk("ws_nbeats_final", obs_addr.size(), 4);
    repeat (2) tick();

    // Ignored start mid-burst, then back-to-back burst
    clear_obs();
    do_start(1, 8'h50, 32'h1F4);
    wait_beats(2);
    do_start(0, 8'h99, 32'h3E7);
    wait_done(30);
    chk("ign_nbeats", obs_addr.size(), 4);
    chk("ign_a3", obs_addr[3], 8'h53); chk("ign_d3", obs_data[3], 32'h1F7);
    clear_obs();
    do_start(1, 8'h60, 32'h258);
    wait_done(30);
    chk("b2b_gap", last_gap, 2);
    chk("b2b_a0", obs_addr[0], 8'h60);
    repeat (2) tick();

    // Reset mid-burst
    clear_obs();
    dc = done_cnt;
    do_start(0, 8'h80, 32'h0);
    wait_beats(3);
    rst_n = 0;
    #1;
    chk("arst_req", req, 0); chk("arst_busy", busy, 0);
    chk("arst_addr", addr, 0); chk("arst_done", done, 0);
    repeat (2) tick();
    rst_n = 1;
    repeat (6) tick();
    chk("arst_no_done", done_cnt, dc);
    clear_obs();
    do_start(0, 8'h20, 32'h0);
    wait_done(30);
    chk("post_rst_nrd", obs_rd.size(), 4);
    chk("post_rst_rd3", obs_rd[3], 32'h23);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
